// File: rtl/gs_basis_extract_pkg.sv
// Shared constants, FSM encoding and width helper for the basis extractor.
// Defaults: DAT_W = l, DAT_D = k, D = d, READ_DELAY = 2.
package gs_basis_extract_pkg;

  localparam int DAT_W_DEF      = 16;
  localparam int DAT_D_DEF      = 8;
  localparam int D_DEF          = 3;
  localparam int READ_DELAY_DEF = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  // Index width that stays >= 1 even for single-entry ranges.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gs_basis_extract_if.sv
// Basis-row output stream: out_data/out_valid from the extractor,
// out_ready from the consumer. master = extractor, slave = consumer.
interface gs_basis_extract_if #(
  parameter int DAT_W = 16
);
  logic [DAT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/gs_basis_extract_row_fifo.sv
// gs_row_fifo: synchronous FIFO, W wide, DEPTH entries, sync active-high rst.
// Ports: push/din in, pop in, dout (head), full, empty, count.
module gs_row_fifo
  import gs_basis_extract_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = cnt_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    // Explicit wrap so non-power-of-two depths work.
    if (do_push)
      wr_d = (wr_q == PW'(DEPTH-1)) ? '0 : wr_q + PW'(1);
    if (do_pop)
      rd_d = (rd_q == PW'(DEPTH-1)) ? '0 : rd_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/gs_basis_extract.sv
// Reads the reduced matrix, streams nonzero rows as the E-support basis
// and reports rank / rank==D. Optional macro: GS_BASIS_EARLY_STOP_EN.
// Ports: clk, rst, start, done, mem_din/mem_addr/mem_rw, out_if (master),
// rank, rank_ok.
module gs_basis_extract
  import gs_basis_extract_pkg::*;
#(
  parameter int DAT_W      = DAT_W_DEF,
  parameter int DAT_D      = DAT_D_DEF,
  parameter int D          = D_DEF,
  parameter int READ_DELAY = READ_DELAY_DEF,
  parameter int AW         = cnt_w(DAT_D),
  parameter int RW         = $clog2(DAT_D+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                done,
  input  logic [DAT_W-1:0]    mem_din,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_rw,
  gs_basis_extract_if.master  out_if,
  output logic [RW-1:0]       rank,
  output logic                rank_ok
);

  localparam int DEPTH = READ_DELAY + 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic [1:0]            state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [READ_DELAY-1:0] vld_q, vld_d;
  logic [RW-1:0]         rank_q, rank_d;
  logic                  rank_ok_q, rank_ok_d;
  logic                  done_q, done_d;

  logic [DAT_W-1:0] fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_cnt;
  logic             issue, push, pop, stop_hit;
  int               pending;

`ifdef GS_BASIS_EARLY_STOP_EN
  assign stop_hit = (rank_q == RW'(D));
`else
  assign stop_hit = 1'b0;
`endif

  // Rows already buffered plus reads still in flight must fit the FIFO,
  // so a returning row always has a slot even under full backpressure.
  assign pending = int'(fifo_cnt) + $countones(vld_q);

  assign issue = (state_q == ST_ISSUE) && !stop_hit
              && !fifo_full && (pending < DEPTH);
  assign push  = vld_q[READ_DELAY-1] && (|mem_din) && !stop_hit;
  assign pop   = !fifo_empty && out_if.out_ready;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = issue;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rank_d    = rank_q;
    rank_ok_d = rank_ok_q;
    done_d    = 1'b0;
    if (push)
      rank_d = rank_q + RW'(1);
    if (issue && addr_q != AW'(DAT_D-1))
      addr_d = addr_q + AW'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ISSUE;
          addr_d    = '0;
          rank_d    = '0;
          rank_ok_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (stop_hit || (issue && addr_q == AW'(DAT_D-1)))
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (vld_q == '0 && fifo_empty) begin
          state_d   = ST_FIN;
          done_d    = 1'b1;
          rank_ok_d = (rank_q == RW'(D));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      vld_q     <= '0;
      rank_q    <= '0;
      rank_ok_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      vld_q     <= vld_d;
      rank_q    <= rank_d;
      rank_ok_q <= rank_ok_d;
      done_q    <= done_d;
    end
  end

  gs_row_fifo #(
    .W     (DAT_W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (mem_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign done             = done_q;
  assign mem_addr         = addr_q;
  assign mem_rw           = 1'b0;
  assign rank             = rank_q;
  assign rank_ok          = rank_ok_q;
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = fifo_empty ? '0 : fifo_dout;

endmodule

// File: tb/tb_gs_basis_extract.sv
// Randomized bench for gs_basis_extract with a queue-based reference model.
// Memory is modelled as an array read through a READ_DELAY address pipe.
module tb_gs_basis_extract;
  import gs_basis_extract_pkg::*;

  localparam int DAT_W = 16;
  localparam int DAT_D = 8;
  localparam int D     = 3;
  localparam int RD    = 2;
  localparam int DEPTH = RD + 2;
  localparam int AW    = $clog2(DAT_D);
  localparam int RW    = $clog2(DAT_D+1);

  logic             clk = 1'b0;
  logic             rst, start, done, mem_rw, rank_ok;
  logic [DAT_W-1:0] mem_din;
  logic [AW-1:0]    mem_addr;
  logic [RW-1:0]    rank;

  gs_basis_extract_if #(.DAT_W(DAT_W)) sif ();

  gs_basis_extract #(
    .DAT_W(DAT_W), .DAT_D(DAT_D), .D(D), .READ_DELAY(RD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .mem_din(mem_din), .mem_addr(mem_addr), .mem_rw(mem_rw),
    .out_if(sif), .rank(rank), .rank_ok(rank_ok)
  );

  always #5 clk = ~clk;

  logic [DAT_W-1:0] mem [DAT_D];
  logic [AW-1:0]    apipe [RD];

  always @(posedge clk) begin
    apipe[0] <= mem_addr;
    for (int i = 1; i < RD; i++) apipe[i] <= apipe[i-1];
  end
  assign mem_din = mem[apipe[RD-1]];

  int checks = 0;
  int errors = 0;

  logic [DAT_W-1:0] got[$];
  logic [DAT_W-1:0] exp_q[$];
  int n_done, max_addr_hold, erank;
  bit timed_out, saw_valid, eok;
  logic [RW-1:0] rank_at_done;
  logic ok_at_done;

  // Reference: nonzero rows in address order, truncated at D if early stop.
  task automatic build_model();
    exp_q.delete();
    for (int i = 0; i < DAT_D; i++) begin
      if (mem[i] != 0) begin
`ifdef GS_BASIS_EARLY_STOP_EN
        if (exp_q.size() < D) exp_q.push_back(mem[i]);
`else
        exp_q.push_back(mem[i]);
`endif
      end
    end
    erank = exp_q.size();
    eok = (erank == D);
  endtask

  task automatic fill(input int nz_pct);
    for (int i = 0; i < DAT_D; i++)
      mem[i] = ($urandom_range(99) < nz_pct) ?
               DAT_W'($urandom_range(1, 16'hFFFF)) : '0;
  endtask

  // Drives one extraction and records popped rows and done pulses.
  task automatic run_op(input int hold_low, input int rdy_pct,
                        input int restart_at);
    int post;
    post = -1;
    got.delete();
    n_done = 0; timed_out = 1; max_addr_hold = 0; saw_valid = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        rank_at_done = rank;
        ok_at_done = rank_ok;
        if (post < 0) post = 5;
      end
      if (sif.out_valid) saw_valid = 1;
      start = (cyc == 0 || cyc == restart_at);
      sif.out_ready = (cyc < hold_low) ? 1'b0 :
                      ($urandom_range(99) < rdy_pct);
      if (cyc > 0 && cyc < hold_low && int'(mem_addr) > max_addr_hold)
        max_addr_hold = int'(mem_addr);
      if (sif.out_valid && sif.out_ready) got.push_back(sif.out_data);
      if (post == 0) begin timed_out = 0; break; end
      if (post > 0) post--;
    end
    start = 0;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; sif.out_ready = 0;
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", done); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rst_addr got %0d exp 0", mem_addr); end
    checks++; if (mem_rw !== 1'b0) begin errors++; $display("FAIL rst_rw got %0b exp 0", mem_rw); end
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", sif.out_valid); end
    checks++; if (sif.out_data !== '0) begin errors++; $display("FAIL rst_data got %0h exp 0", sif.out_data); end
    checks++; if (rank !== '0) begin errors++; $display("FAIL rst_rank got %0d exp 0", rank); end
    checks++; if (rank_ok !== 1'b0) begin errors++; $display("FAIL rst_rank_ok got %0b exp 0", rank_ok); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_sparse();
    for (int i = 0; i < DAT_D; i++) mem[i] = '0;
    mem[1] = 16'h0001; mem[4] = 16'h0010; mem[6] = 16'h0080;
    build_model();
    run_op(0, 100, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL sparse_timeout got 1 exp 0"); end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL sparse_count got %0d exp 3", got.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL sparse_row%0d got %0h exp %0h", i, got[i], exp_q[i]); end
    end
    checks++; if (rank_at_done !== RW'(3)) begin errors++; $display("FAIL sparse_rank got %0d exp 3", rank_at_done); end
    checks++; if (ok_at_done !== 1'b1) begin errors++; $display("FAIL sparse_ok got %0b exp 1", ok_at_done); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL sparse_done got %0d exp 1", n_done); end
    checks++; if (rank !== RW'(3)) begin errors++; $display("FAIL sparse_rank_hold got %0d exp 3", rank); end
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < DAT_D; i++) mem[i] = '0;
    run_op(0, 100, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL zero_timeout got 1 exp 0"); end
    checks++; if (saw_valid) begin errors++; $display("FAIL zero_valid got 1 exp 0"); end
    checks++; if (rank_at_done !== '0) begin errors++; $display("FAIL zero_rank got %0d exp 0", rank_at_done); end
    checks++; if (ok_at_done !== 1'b0) begin errors++; $display("FAIL zero_ok got %0b exp 0", ok_at_done); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL zero_done got %0d exp 1", n_done); end
  endtask

  task automatic test_five();
    for (int i = 0; i < DAT_D; i++) mem[i] = '0;
    mem[0] = 16'hA001; mem[2] = 16'h0B02; mem[3] = 16'h00C3;
    mem[5] = 16'h8000; mem[7] = 16'h1234;
    build_model();
    run_op(0, 100, -1);
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL five_count got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL five_row%0d got %0h exp %0h", i, got[i], exp_q[i]); end
    end
    checks++; if (rank_at_done !== RW'(erank)) begin errors++; $display("FAIL five_rank got %0d exp %0d", rank_at_done, erank); end
    checks++; if (ok_at_done !== eok) begin errors++; $display("FAIL five_ok got %0b exp %0b", ok_at_done, eok); end
  endtask

  task automatic test_backpressure();
    fill(100);
    build_model();
    run_op(20, 100, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout got 1 exp 0"); end
    checks++; if (max_addr_hold != DEPTH) begin errors++; $display("FAIL bp_stall_addr got %0d exp %0d", max_addr_hold, DEPTH); end
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL bp_row%0d got %0h exp %0h", i, got[i], exp_q[i]); end
    end
    checks++; if (rank_at_done !== RW'(erank)) begin errors++; $display("FAIL bp_rank got %0d exp %0d", rank_at_done, erank); end
  endtask

  task automatic test_reset_mid();
    bit hit;
    fill(100);
    sif.out_ready = 1;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      if (mem_addr == AW'(3)) hit = 1;
      else @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL midrst_addr3 got 0 exp 1"); end
    rst = 1;
    @(negedge clk);
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b exp 0", sif.out_valid); end
    checks++; if (rank !== '0) begin errors++; $display("FAIL midrst_rank got %0d exp 0", rank); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL midrst_mem_addr got %0d exp 0", mem_addr); end
    rst = 0;
    repeat (RD + 2) @(negedge clk);
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_flushed got %0b exp 0", sif.out_valid); end
    fill(60);
    build_model();
    run_op(0, 100, -1);
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL midrst_count got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_row%0d got %0h exp %0h", i, got[i], exp_q[i]); end
    end
    checks++; if (rank_at_done !== RW'(erank)) begin errors++; $display("FAIL midrst_rank2 got %0d exp %0d", rank_at_done, erank); end
  endtask

  task automatic test_start_in_drain();
    for (int i = 0; i < DAT_D; i++) mem[i] = '0;
    mem[5] = 16'h0505; mem[6] = 16'h0606; mem[7] = 16'h0707;
    build_model();
    run_op(16, 100, 13);
    checks++; if (n_done != 1) begin errors++; $display("FAIL drain_done got %0d exp 1", n_done); end
    checks++; if (rank_at_done !== RW'(erank)) begin errors++; $display("FAIL drain_rank got %0d exp %0d", rank_at_done, erank); end
    checks++; if (rank !== RW'(erank)) begin errors++; $display("FAIL drain_rank_hold got %0d exp %0d", rank, erank); end
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL drain_count got %0d exp %0d", got.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 15; it++) begin
      fill(50);
      build_model();
      run_op(int'($urandom_range(0, 6)), int'($urandom_range(40, 100)), -1);
      checks++; if (timed_out) begin errors++; $display("FAIL rnd%0d_timeout got 1 exp 0", it); end
      checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d exp %0d", it, got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_row%0d got %0h exp %0h", it, i, got[i], exp_q[i]); end
      end
      checks++; if (rank_at_done !== RW'(erank)) begin errors++; $display("FAIL rnd%0d_rank got %0d exp %0d", it, rank_at_done, erank); end
      checks++; if (ok_at_done !== eok) begin errors++; $display("FAIL rnd%0d_ok got %0b exp %0b", it, ok_at_done, eok); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL rnd%0d_done got %0d exp 1", it, n_done); end
    end
  endtask

  initial begin
    for (int i = 0; i < DAT_D; i++) mem[i] = '0;
    test_reset();
    test_sparse();
    test_all_zero();
    test_five();
    test_backpressure();
    test_reset_mid();
    test_start_in_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
